volt_text_sequencer: RTL and testbench

Schedules the shared, registered BCD-to-ASCII digit converter among the 13 voltage channels. Channels raise a request when a fresh 4-digit BCD reading is ready. The block grants one channel round-robin and streams its digits through the converter. It writes the formatted text "d.dddV" into the character buffer consumed by the display renderer.

---
 rtl/volt_text_pkg.sv | 26 ++
 rtl/volt_text_sequencer_rr_arbiter.sv | 32 +++
 rtl/volt_text_sequencer.sv | 115 +++++++++++
 tb/tb_volt_text_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/volt_text_pkg.sv
// Shared types and constants for the voltage text sequencer.
// Pure declarations: no logic, no latency, no flow control.
package volt_text_pkg;

  localparam int N_CH           = 13;
  localparam int LINE_STRIDE    = 8;
  localparam int CHARS_PER_LINE = 6;

  localparam logic [6:0] ASCII_DOT = 7'h2E;
  localparam logic [6:0] ASCII_V   = 7'h56;

  localparam logic [2:0] POS_DOT = 3'd1;
  localparam logic [2:0] POS_V   = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } state_t;

  function automatic logic is_literal(input logic [2:0] pos);
    return (pos == POS_DOT) || (pos == POS_V);
  endfunction

endpackage

// File: rtl/volt_text_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after rr_ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to take the grant.
module rr_arbiter #(
  parameter int N_CH  = 13,
  parameter int IDX_W = 4
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  int               idx;
  logic [IDX_W-1:0] sel;

  // Scan farthest-first so the nearest requester after rr_ptr overwrites the rest.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    sel       = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(rr_ptr) + i) % N_CH;
      sel = IDX_W'(idx);
      if (req[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/volt_text_sequencer.sv
// Shares one registered BCD-to-ASCII converter among N_CH channels, writing "d.dddV" lines.
// 9 cycles per line (grant to IDLE); requesters wait on level ch_req until their ch_ack pulse.
module volt_text_sequencer #(
  parameter int N_CH        = volt_text_pkg::N_CH,
  parameter int LINE_STRIDE = volt_text_pkg::LINE_STRIDE,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_req,
  output logic [N_CH-1:0]   ch_ack,
  output logic [3:0]        chan_sel,
  input  logic [15:0]       bcd_in,
  output logic [3:0]        conv_bcd,
  input  logic [6:0]        conv_ascii,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic              busy
);

  import volt_text_pkg::*;

  state_t            state, state_nxt;
  logic [3:0]        rr_ptr;
  logic [15:0]       digit;
  logic [2:0]        pos;
  logic              gnt_valid;
  logic [3:0]        gnt_idx;

  // Delay stage lines the literal path up with the converter's one-cycle latency.
  logic              dly_vld;
  logic [ADDR_W-1:0] dly_addr;
  logic              dly_lit;
  logic [6:0]        dly_char;

  rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (4)
  ) u_arb (
    .req       (ch_req),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 4'(N_CH - 1);
      chan_sel <= '0;
      conv_bcd <= '0;
      digit    <= '0;
      pos      <= '0;
      dly_vld  <= 1'b0;
      dly_addr <= '0;
      dly_lit  <= 1'b0;
      dly_char <= '0;
    end else begin
      state    <= state_nxt;
      dly_vld  <= (state == EMIT);
      dly_addr <= ADDR_W'(chan_sel * LINE_STRIDE + pos);
      dly_lit  <= is_literal(pos);
      dly_char <= (pos == POS_DOT) ? ASCII_DOT : ASCII_V;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            chan_sel <= gnt_idx;
            rr_ptr   <= gnt_idx;
          end
        end
        LOAD: begin
          digit    <= bcd_in;
          pos      <= '0;
          conv_bcd <= bcd_in[15:12];
        end
        EMIT: begin
          pos <= pos + 3'd1;
          // conv_bcd is loaded one position ahead; literal slots leave it untouched.
          case (pos)
            3'd1:    conv_bcd <= digit[11:8];
            3'd2:    conv_bcd <= digit[7:4];
            3'd3:    conv_bcd <= digit[3:0];
            default: conv_bcd <= conv_bcd;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ch_ack    = '0;
    busy      = (state != IDLE);
    wr_en     = dly_vld;
    wr_addr   = '0;
    wr_data   = '0;
    if (dly_vld) begin
      wr_addr = dly_addr;
      wr_data = dly_lit ? dly_char : conv_ascii;
    end
    case (state)
      IDLE: if (gnt_valid) state_nxt = LOAD;
      LOAD: state_nxt = EMIT;
      EMIT: if (pos == 3'(CHARS_PER_LINE - 1)) state_nxt = DONE;
      DONE: begin
        state_nxt        = IDLE;
        ch_ack[chan_sel] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_volt_text_sequencer.sv
// Directed bench for volt_text_sequencer with a registered converter model and an external bcd mux.
module tb_volt_text_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] ch_req;
  logic [12:0] ch_ack;
  logic [3:0]  chan_sel;
  logic [15:0] bcd_in;
  logic [3:0]  conv_bcd;
  logic [6:0]  conv_ascii;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [6:0]  wr_data;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] bcd_tab [13];

  typedef struct {
    int         cyc;
    logic [6:0] addr;
    logic [6:0] data;
  } wr_t;

  wr_t         wr_q[$];
  int          ack_cyc_q[$];
  logic [12:0] ack_val_q[$];
  int          gnt_cyc_q[$];
  logic [3:0]  gnt_ch_q[$];
  logic        busy_d = 1'b0;

  volt_text_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .ch_req     (ch_req),
    .ch_ack     (ch_ack),
    .chan_sel   (chan_sel),
    .bcd_in     (bcd_in),
    .conv_bcd   (conv_bcd),
    .conv_ascii (conv_ascii),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb bcd_in = (chan_sel < 4'd13) ? bcd_tab[chan_sel] : 16'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    conv_ascii <= (conv_bcd <= 4'd9) ? (7'h30 + {3'b0, conv_bcd})
                                     : (7'h41 + {3'b0, conv_bcd} - 7'd10);
  end

  always @(negedge clk) begin
    wr_t w;
    if (wr_en === 1'b1) begin
      w.cyc = cyc; w.addr = wr_addr; w.data = wr_data;
      wr_q.push_back(w);
    end
    if (ch_ack !== 13'h0) begin
      ack_cyc_q.push_back(cyc);
      ack_val_q.push_back(ch_ack);
    end
    if (busy === 1'b1 && !busy_d) begin
      gnt_cyc_q.push_back(cyc);
      gnt_ch_q.push_back(chan_sel);
    end
    busy_d <= (busy === 1'b1);
  end

  task automatic clear_logs();
    wr_q.delete(); ack_cyc_q.delete(); ack_val_q.delete();
    gnt_cyc_q.delete(); gnt_ch_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_req = '0;
    repeat (2) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 7'h0) begin failures++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    checks++; if (wr_data !== 7'h0) begin failures++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    checks++; if (ch_ack !== 13'h0) begin failures++; $display("FAIL reset_ch_ack: got %0h want 0", ch_ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (chan_sel !== 4'h0) begin failures++; $display("FAIL reset_chan_sel: got %0h want 0", chan_sel); end
    checks++; if (conv_bcd !== 4'h0) begin failures++; $display("FAIL reset_conv_bcd: got %0h want 0", conv_bcd); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || ch_ack !== 13'h0 || busy !== 1'b0 || conv_bcd !== 4'h0) begin
        failures++;
        $display("FAIL idle_quiet: wr_en=%b ack=%0h busy=%b conv_bcd=%0h want all 0", wr_en, ch_ack, busy, conv_bcd);
      end
    end
  endtask

  task automatic test_single();
    int c0;
    logic [6:0] exp_d [6];
    exp_d = '{7'h33, 7'h2E, 7'h31, 7'h34, 7'h32, 7'h56};
    bcd_tab[0] = 16'h3142;
    clear_logs();
    @(negedge clk);
    c0 = cyc; ch_req = 13'h0001;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== (k <= 8)) begin failures++; $display("FAIL single_busy cycle %0d: got %b want %b", k, busy, (k <= 8)); end
      if (k == 3) begin
        checks++;
        if (conv_bcd !== 4'h3) begin failures++; $display("FAIL single_conv_hold_dot: got %0h want 3", conv_bcd); end
      end
      if (k == 8) ch_req = '0;
    end
    @(negedge clk);
    checks++;
    if (wr_q.size() != 6) begin failures++; $display("FAIL single_write_count: got %0d want 6", wr_q.size()); end
    for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].cyc != c0 + 3 + i || wr_q[i].addr !== 7'(i) || wr_q[i].data !== exp_d[i]) begin
        failures++;
        $display("FAIL single_write%0d: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                 i, wr_q[i].cyc - c0, wr_q[i].addr, wr_q[i].data, 3 + i, i, exp_d[i]);
      end
    end
    checks++;
    if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != c0 + 8 || ack_val_q[0] !== 13'h0001) begin
      failures++;
      $display("FAIL single_ack: got count=%0d want one ack of 0001 at cycle 8", ack_cyc_q.size());
    end
    checks++;
    if (conv_bcd !== 4'h2) begin failures++; $display("FAIL single_conv_final: got %0h want 2", conv_bcd); end
  endtask

  task automatic test_invalid_digit();
    logic [6:0] exp_d [6];
    exp_d = '{7'h41, 7'h2E, 7'h30, 7'h30, 7'h30, 7'h56};
    bcd_tab[1] = 16'hA000;
    clear_logs();
    @(negedge clk);
    ch_req = 13'h0002;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 8) ch_req = '0;
    end
    checks++;
    if (wr_q.size() != 6) begin failures++; $display("FAIL invalid_write_count: got %0d want 6", wr_q.size()); end
    for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].addr !== 7'(8 + i) || wr_q[i].data !== exp_d[i]) begin
        failures++;
        $display("FAIL invalid_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h",
                 i, wr_q[i].addr, wr_q[i].data, 8 + i, exp_d[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int c0, acks, n12;
    logic [6:0] exp_d [6];
    exp_d = '{7'h39, 7'h2E, 7'h38, 7'h37, 7'h36, 7'h56};
    for (int i = 0; i < 13; i++) bcd_tab[i] = 16'h1000 + 16'(i);
    bcd_tab[12] = 16'h9876;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    c0 = cyc; ch_req = 13'h1FFF; acks = 0;
    for (int k = 0; k < 200 && acks < 14; k++) begin
      @(negedge clk);
      if (ch_ack !== 13'h0) acks++;
      if (acks == 14) ch_req = '0;
    end
    ch_req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt_ch_q.size() != 14) begin failures++; $display("FAIL rr_grant_count: got %0d want 14", gnt_ch_q.size()); end
    checks++;
    if (gnt_cyc_q.size() == 0 || gnt_cyc_q[0] != c0 + 1) begin
      failures++; $display("FAIL rr_first_grant: got size=%0d want LOAD at cycle 1", gnt_cyc_q.size());
    end
    for (int i = 0; i < 14 && i < gnt_ch_q.size(); i++) begin
      checks++;
      if (gnt_ch_q[i] !== 4'(i % 13) || (i > 0 && gnt_cyc_q[i] - gnt_cyc_q[i-1] != 9)) begin
        failures++;
        $display("FAIL rr_grant%0d: got ch=%0d want ch=%0d spaced 9", i, gnt_ch_q[i], i % 13);
      end
    end
    checks++;
    if (wr_q.size() != 84) begin failures++; $display("FAIL rr_write_count: got %0d want 84", wr_q.size()); end
    n12 = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (wr_q[i].addr >= 7'd96 && n12 < 6) begin
        checks++;
        if (wr_q[i].addr !== 7'(96 + n12) || wr_q[i].data !== exp_d[n12]) begin
          failures++;
          $display("FAIL rr_ch12_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h",
                   n12, wr_q[i].addr, wr_q[i].data, 96 + n12, exp_d[n12]);
        end
        n12++;
      end
    end
    checks++;
    if (n12 != 6) begin failures++; $display("FAIL rr_ch12_count: got %0d want 6", n12); end
  endtask

  task automatic test_wrap_priority();
    int acks;
    clear_logs();
    @(negedge clk);
    ch_req = 13'h0800; acks = 0;
    for (int k = 0; k < 60 && acks < 3; k++) begin
      @(negedge clk);
      if (ch_ack !== 13'h0) begin
        acks++;
        if (acks == 1) ch_req = 13'h1008;
        else if (acks == 2) ch_req = 13'h0008;
        else ch_req = '0;
      end
    end
    ch_req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt_ch_q.size() != 3) begin
      failures++; $display("FAIL wrap_grant_count: got %0d want 3", gnt_ch_q.size());
    end else begin
      checks++;
      if (gnt_ch_q[0] !== 4'd11 || gnt_ch_q[1] !== 4'd12 || gnt_ch_q[2] !== 4'd3) begin
        failures++;
        $display("FAIL wrap_order: got %0d,%0d,%0d want 11,12,3", gnt_ch_q[0], gnt_ch_q[1], gnt_ch_q[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [6:0] exp_d [6];
    exp_d = '{7'h31, 7'h2E, 7'h32, 7'h33, 7'h34, 7'h56};
    bcd_tab[5] = 16'h1234;
    clear_logs();
    @(negedge clk);
    c0 = cyc; ch_req = 13'h0020;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || ch_ack !== 13'h0) begin
          failures++; $display("FAIL mid_reset_abort: wr_en=%b busy=%b ack=%0h want 0,0,0", wr_en, busy, ch_ack);
        end
        rst = 1'b0;
      end
      if (k == 6 || k == 7) begin
        checks++;
        if (wr_en !== 1'b0) begin failures++; $display("FAIL mid_reset_quiet cycle %0d: got wr_en=%b want 0", k, wr_en); end
      end
      if (k == 13) ch_req = '0;
    end
    checks++;
    if (wr_q.size() != 8) begin
      failures++; $display("FAIL mid_write_count: got %0d want 8", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0].cyc != c0 + 3 || wr_q[1].cyc != c0 + 4 || wr_q[0].addr !== 7'd40 || wr_q[1].addr !== 7'd41
          || wr_q[0].data !== 7'h31 || wr_q[1].data !== 7'h2E) begin
        failures++; $display("FAIL mid_partial: got addr=%0d,%0d data=%0h,%0h want 40,41 31,2e",
                             wr_q[0].addr, wr_q[1].addr, wr_q[0].data, wr_q[1].data);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_q[2+i].cyc != c0 + 8 + i || wr_q[2+i].addr !== 7'(40 + i) || wr_q[2+i].data !== exp_d[i]) begin
          failures++;
          $display("FAIL mid_rewrite%0d: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                   i, wr_q[2+i].cyc - c0, wr_q[2+i].addr, wr_q[2+i].data, 8 + i, 40 + i, exp_d[i]);
        end
      end
    end
    checks++;
    if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != c0 + 13 || ack_val_q[0] !== 13'h0020) begin
      failures++; $display("FAIL mid_ack: got count=%0d want one ack of 0020 at cycle 13", ack_cyc_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; ch_req = '0;
    for (int i = 0; i < 13; i++) bcd_tab[i] = 16'h0;
    test_reset();
    test_idle();
    test_single();
    test_invalid_digit();
    test_round_robin();
    test_wrap_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
